// File: rtl/coproc_dispatch.sv
// Shared-execution-unit dispatcher: accepts a one-hot grant, latches that requester's
// operands and runs add/sub/and (1 cycle) or shift-add multiply (data_w cycles).
module coproc_dispatch #(
    parameter int unsigned width  = 4,
    parameter int unsigned data_w = 8
) (
    input  logic                      in_clk,
    input  logic                      in_reset,
    input  logic [width-1:0]          in_grant,
    input  logic [width*data_w-1:0]   in_op_a,
    input  logic [width*data_w-1:0]   in_op_b,
    input  logic [2*width-1:0]        in_opcode,
    output logic [2*data_w-1:0]       out_result,
    output logic [width-1:0]          out_done,
    output logic                      out_busy,
    output logic                      out_error
);

    localparam int unsigned IDX_W = (width > 1) ? $clog2(width) : 1;
    localparam int unsigned RES_W = 2 * data_w;
    localparam int unsigned CNT_W = $clog2(data_w) + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE, S_RELEASE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_MUL = 2'b11} op_t;

    state_t             state;
    op_t                op_q;
    logic [IDX_W-1:0]   idx_q;
    logic [RES_W-1:0]   a_q;
    logic [data_w-1:0]  b_q;
    logic [RES_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [IDX_W-1:0]   grant_idx_c;
    logic               grant_ok_c;
    logic               grant_bad_c;
    logic [data_w:0]    sum_c;
    logic [data_w:0]    diff_c;
    logic [RES_W-1:0]   mul_step_c;
    logic               exec_done_c;
    logic [RES_W-1:0]   exec_res_c;

    // Encode the granted requester's index.
    always_comb begin
        grant_idx_c = '0;
        for (int unsigned i = 0; i < width; i++) begin
            if (in_grant[i]) grant_idx_c = IDX_W'(i);
        end
    end

    assign grant_ok_c  = $onehot(in_grant);
    assign grant_bad_c = (|in_grant) && !grant_ok_c;

    // Shared datapath; the subtract's extra top bit is the borrow.
    assign sum_c      = {1'b0, a_q[data_w-1:0]} + {1'b0, b_q};
    assign diff_c     = {1'b0, a_q[data_w-1:0]} - {1'b0, b_q};
    assign mul_step_c = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        exec_done_c = (op_q != OP_MUL) || (cnt_q == CNT_W'(data_w - 1));
        exec_res_c  = '0;
        case (op_q)
            OP_ADD:  exec_res_c = RES_W'(sum_c);
            OP_SUB:  exec_res_c = RES_W'(diff_c);
            OP_AND:  exec_res_c = RES_W'(a_q[data_w-1:0] & b_q);
            default: exec_res_c = mul_step_c;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state      <= S_IDLE;
            op_q       <= OP_ADD;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_result <= '0;
            out_done   <= '0;
            out_busy   <= 1'b0;
            out_error  <= 1'b0;
        end else begin
            out_done  <= '0;
            out_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_ok_c) begin
                        idx_q    <= grant_idx_c;
                        a_q      <= RES_W'(in_op_a[grant_idx_c*data_w +: data_w]);
                        b_q      <= in_op_b[grant_idx_c*data_w +: data_w];
                        op_q     <= op_t'(in_opcode[grant_idx_c*2 +: 2]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state    <= S_EXEC;
                        out_busy <= 1'b1;
                    end else if (grant_bad_c) begin
                        out_error <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // A dropped grant abandons the operation without touching the result.
                    if (!in_grant[idx_q]) begin
                        state    <= S_IDLE;
                        out_busy <= 1'b0;
                    end else if (exec_done_c) begin
                        out_result <= exec_res_c;
                        out_done   <= width'(1) << idx_q;
                        state      <= S_DONE;
                    end else begin
                        acc_q <= mul_step_c;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!in_grant[idx_q]) begin
                        state    <= S_IDLE;
                        out_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    out_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coproc_dispatch.sv
// Self-checking bench for coproc_dispatch: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_coproc_dispatch;

    localparam int unsigned W  = 4;
    localparam int unsigned DW = 8;

    logic              in_clk = 1'b0;
    logic              in_reset;
    logic [W-1:0]      in_grant;
    logic [W*DW-1:0]   in_op_a;
    logic [W*DW-1:0]   in_op_b;
    logic [2*W-1:0]    in_opcode;
    logic [2*DW-1:0]   out_result;
    logic [W-1:0]      out_done;
    logic              out_busy;
    logic              out_error;

    int errors = 0;
    int checks = 0;
    logic [2*DW-1:0] last_res;

    coproc_dispatch #(.width(W), .data_w(DW)) dut (
        .in_clk    (in_clk),
        .in_reset  (in_reset),
        .in_grant  (in_grant),
        .in_op_a   (in_op_a),
        .in_op_b   (in_op_b),
        .in_opcode (in_opcode),
        .out_result(out_result),
        .out_done  (out_done),
        .out_busy  (out_busy),
        .out_error (out_error)
    );

    always #5 in_clk = ~in_clk;

    // Reference: plain arithmetic on integers.
    function automatic logic [2*DW-1:0] ref_result(input int a, input int b, input int op);
        case (op)
            0:       return 16'(a + b);
            1:       return 16'(((a < b) ? 256 : 0) + ((a - b + 256) % 256));
            2:       return 16'(a & b);
            default: return 16'(a * b);
        endcase
    endfunction

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [1:0] op);
        in_op_a[idx*DW +: DW] = a;
        in_op_b[idx*DW +: DW] = b;
        in_opcode[idx*2 +: 2] = op;
    endtask

    // Drops the grant and waits (bounded) for busy to fall; ok=0 if it never does.
    task automatic release_grant(output bit ok);
        in_grant = '0;
        ok = 1'b0;
        for (int c = 0; c < 5 && !ok; c++) begin
            tick();
            if (out_busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        in_reset = 1'b0; in_grant = '0;
        in_op_a = '0; in_op_b = '0; in_opcode = '0;
        #3;
        checks++;
        if ({out_result, out_done, out_busy, out_error} !== '0) begin
            errors++;
            $display("FAIL reset_values: got result=%h done=%b busy=%b err=%b, want all 0",
                     out_result, out_done, out_busy, out_error);
        end
        tick(); tick();
        in_reset = 1'b1;
        tick();
        checks++;
        if (out_busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b want 0", out_busy);
        end
        last_res = '0;
    endtask

    task automatic test_add();
        bit ok;
        set_req(2, 8'd200, 8'd100, 2'b00);
        in_grant = 4'b0100;
        tick();
        checks++;
        if (out_busy !== 1'b1 || out_done !== 4'b0000) begin
            errors++; $display("FAIL add_accept: busy=%b done=%b want 1/0000", out_busy, out_done);
        end
        tick();
        checks++;
        if (out_result !== 16'h012C || out_done !== 4'b0100) begin
            errors++; $display("FAIL add_result: result=%h done=%b want 012c/0100", out_result, out_done);
        end
        last_res = 16'h012C;
        tick();
        checks++;
        if (out_done !== 4'b0000 || out_busy !== 1'b1) begin
            errors++; $display("FAIL add_done_width: done=%b busy=%b want 0000/1", out_done, out_busy);
        end
        release_grant(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL add_release: busy=%b want 0", out_busy); end
    endtask

    task automatic test_sub();
        bit ok;
        set_req(0, 8'd5, 8'd7, 2'b01);
        in_grant = 4'b0001;
        tick(); tick();
        checks++;
        if (out_result !== 16'h01FE || out_done !== 4'b0001) begin
            errors++; $display("FAIL sub_borrow: result=%h done=%b want 01fe/0001", out_result, out_done);
        end
        last_res = 16'h01FE;
        release_grant(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sub_release: busy=%b want 0", out_busy); end
    endtask

    task automatic test_mul();
        bit ok;
        int pulses = 0;
        set_req(3, 8'hFF, 8'hFF, 2'b11);
        in_grant = 4'b1000;
        tick();
        set_req(3, 8'h01, 8'hFF, 2'b11);
        for (int c = 1; c < int'(DW); c++) begin
            tick();
            checks++;
            if (out_done !== 4'b0000 || out_result !== last_res) begin
                errors++;
                $display("FAIL mul_early cycle %0d: done=%b result=%h want 0000/%h",
                         c, out_done, out_result, last_res);
            end
        end
        tick();
        checks++;
        if (out_result !== 16'hFE01 || out_done !== 4'b1000) begin
            errors++; $display("FAIL mul_result: result=%h done=%b want fe01/1000", out_result, out_done);
        end
        last_res = 16'hFE01;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (out_done !== 4'b0000) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL mul_single_pulse: extra=%0d want 0", pulses); end
        release_grant(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mul_release: busy=%b want 0", out_busy); end
    endtask

    task automatic test_abort();
        int pulses = 0;
        set_req(1, 8'($urandom), 8'($urandom), 2'b11);
        in_grant = 4'b0010;
        tick(); tick(); tick();
        in_grant = 4'b0000;
        tick();
        checks++;
        if (out_busy !== 1'b0 || out_done !== 4'b0000 || out_result !== last_res) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b result=%h want 0/0000/%h",
                     out_busy, out_done, out_result, last_res);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_done !== 4'b0000 || out_result !== last_res) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL abort_quiet: bad cycles=%0d want 0", pulses); end
    endtask

    task automatic test_error();
        logic [W-1:0] bad [3] = '{4'b0110, 4'b1010, 4'b1111};
        for (int k = 0; k < 3; k++) begin
            in_grant = bad[k];
            tick();
            checks++;
            if (out_error !== 1'b1 || out_busy !== 1'b0) begin
                errors++; $display("FAIL error_pulse %b: err=%b busy=%b want 1/0", bad[k], out_error, out_busy);
            end
            in_grant = '0;
            tick();
            checks++;
            if (out_error !== 1'b0 || out_busy !== 1'b0) begin
                errors++; $display("FAIL error_width %b: err=%b busy=%b want 0/0", bad[k], out_error, out_busy);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        bit ok;
        int pulses = 0;
        set_req(3, 8'hFF, 8'hFF, 2'b11);
        in_grant = 4'b1000;
        tick(); tick(); tick();
        #2 in_reset = 1'b0;
        #1;
        checks++;
        if ({out_result, out_done, out_busy, out_error} !== '0) begin
            errors++;
            $display("FAIL reset_mid_mul: result=%h done=%b busy=%b err=%b want all 0",
                     out_result, out_done, out_busy, out_error);
        end
        in_grant = '0;
        last_res = '0;
        tick(); tick();
        #2 in_reset = 1'b1;
        for (int c = 0; c < int'(DW) + 2; c++) begin
            tick();
            if (out_done !== 4'b0000 || out_busy !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL reset_no_done: bad cycles=%0d want 0", pulses); end
        set_req(0, 8'd1, 8'd2, 2'b00);
        in_grant = 4'b0001;
        tick(); tick();
        checks++;
        if (out_result !== 16'h0003 || out_done !== 4'b0001) begin
            errors++; $display("FAIL reset_recover: result=%h done=%b want 0003/0001", out_result, out_done);
        end
        last_res = 16'h0003;
        release_grant(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_recover_release: busy=%b", out_busy); end
    endtask

    // Round-robin arbiter model driving the dispatcher; requesters drop on done.
    task automatic test_arbiter();
        logic [W-1:0] req = 4'b0011;
        logic [W-1:0] g = '0;
        int ptr = 0;
        int order[$];
        logic [2*DW-1:0] exp [W];
        int bad_res = 0;
        int cyc = 0;
        for (int r = 0; r < 2; r++) begin
            int a = $urandom_range(0, 255), b = $urandom_range(0, 255), op = $urandom_range(0, 2);
            set_req(r, 8'(a), 8'(b), 2'(op));
            exp[r] = ref_result(a, b, op);
        end
        while ((req != '0 || out_busy) && cyc < 80) begin
            if (g != '0) begin
                if ((g & req) == '0) g = '0;
            end else if (req != '0) begin
                bit found = 1'b0;
                for (int k = 0; k < int'(W) && !found; k++) begin
                    int j = (ptr + k) % int'(W);
                    if (req[j]) begin g = W'(1) << j; ptr = (j + 1) % int'(W); found = 1'b1; end
                end
            end
            in_grant = g;
            tick();
            cyc++;
            if (out_done != '0) begin
                for (int k = 0; k < int'(W); k++) begin
                    if (out_done[k]) begin
                        order.push_back(k);
                        if (out_result !== exp[k]) bad_res++;
                        last_res = exp[k];
                    end
                end
                req = req & ~out_done;
            end
        end
        in_grant = '0;
        checks++;
        if (cyc >= 80) begin errors++; $display("FAIL arb_timeout: req=%b busy=%b", req, out_busy); end
        checks++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
            errors++; $display("FAIL arb_order: pulses=%0d want 2 (req0 then req1)", order.size());
        end
        checks++;
        if (bad_res != 0) begin errors++; $display("FAIL arb_results: wrong=%0d want 0", bad_res); end
        tick();
    endtask

    task automatic test_random_ops();
        for (int t = 0; t < 24; t++) begin
            bit ok;
            int idx = $urandom_range(0, W - 1);
            int a = $urandom_range(0, 255), b = $urandom_range(0, 255), op = $urandom_range(0, 3);
            int lat = (op == 3) ? int'(DW) : 1;
            logic [2*DW-1:0] exp = ref_result(a, b, op);
            in_op_a = $urandom; in_op_b = $urandom; in_opcode = 8'($urandom);
            set_req(idx, 8'(a), 8'(b), 2'(op));
            in_grant = W'(1) << idx;
            tick();
            checks++;
            if (out_busy !== 1'b1) begin errors++; $display("FAIL rnd_accept %0d: busy=%b want 1", t, out_busy); end
            in_op_a = $urandom; in_op_b = $urandom; in_opcode = 8'($urandom);
            for (int c = 1; c <= lat + 1; c++) begin
                logic [W-1:0] want_done = (c == lat) ? (W'(1) << idx) : '0;
                logic [2*DW-1:0] want_res = (c >= lat) ? exp : last_res;
                tick();
                checks++;
                if (out_done !== want_done || out_result !== want_res) begin
                    errors++;
                    $display("FAIL rnd_op %0d op=%0d a=%0d b=%0d cyc=%0d: result=%h done=%b want %h/%b",
                             t, op, a, b, c, out_result, out_done, want_res, want_done);
                end
            end
            last_res = exp;
            repeat ($urandom_range(0, 2)) tick();
            release_grant(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rnd_release %0d: busy=%b want 0", t, out_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_abort();
        test_error();
        test_reset_mid_mul();
        test_arbiter();
        test_random_ops();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coproc_dispatch.md
# coproc_dispatch

Shared-execution-unit dispatcher sitting directly downstream of the coprocessor's round-robin arbiter. It consumes the arbiter's one-hot grant vector, latches the granted requester's operands and opcode, and executes the operation on a single shared datapath (add, sub, and, multi-cycle shift-add multiply). It returns the result with a one-cycle done pulse addressed to the granted requester, then waits for the grant to be released before accepting new work.

## Interface
- `width`, default 4: number of requesters; matches the arbiter's `width`.
- `data_w`, default 8: operand width in bits.
- `in_clk` input 1: clock; all state updates on the rising edge.
- `in_reset` input 1: asynchronous, active-low reset.
- `in_grant` input `width`: grant vector from the arbiter; expected one-hot or zero.
- `in_op_a` input `width*data_w`: operand A per requester; requester i uses bits [i*data_w +: data_w].
- `in_op_b` input `width*data_w`: operand B per requester, packed the same way.
- `in_opcode` input `2*width`: opcode per requester, bits [2i +: 2]. 00 = add, 01 = sub, 10 = and, 11 = mul.
- `out_result` output `2*data_w`: result of the last completed operation; held until the next completion.
- `out_done` output `width`: one-hot, one-cycle pulse on bit i when requester i's result is valid.
- `out_busy` output 1: high whenever the FSM is not in S_IDLE.
- `out_error` output 1: one-cycle pulse when a non-one-hot, non-zero grant is sampled in S_IDLE.

## Operation
- FSM states: S_IDLE, S_EXEC, S_DONE, S_RELEASE.
- **S_IDLE**
  - `in_grant` one-hot: record index i, latch A_i, B_i, op_i, clear the accumulator, go to S_EXEC.
  - `in_grant` zero: stay in S_IDLE.
  - `in_grant` with more than one bit set: stay in S_IDLE and pulse `out_error`.
- **S_EXEC**
  - add: result = zero-extended {carry, A+B}; bit data_w holds the carry.
  - sub: result[data_w-1:0] = A−B modulo 2^data_w; bit data_w = borrow (A<B); upper bits zero.
  - and: result = zero-extended A&B.
  - add, sub and and complete in 1 cycle.
  - mul: unsigned shift-add, one multiplier bit per cycle, LSB first. Takes data_w cycles; the full 2*data_w product goes to `out_result`.
  - On completion: write `out_result`, set `out_done[i]`, go to S_DONE.
- **S_DONE**: clear `out_done`, go to S_RELEASE.
- **S_RELEASE**
  - Wait until `in_grant[i]` = 0, then go to S_IDLE.
  - A requester must drop its request after seeing `out_done[i]`. The arbiter then deasserts the grant and rotates priority.
- **Abort**: if `in_grant[i]` falls while in S_EXEC, go to S_IDLE. `out_done` is not pulsed and `out_result` is unchanged.
- Operand and opcode inputs are sampled only at acceptance. Later changes do not affect an in-flight operation.
- `out_result` is not cleared on S_IDLE or on abort; only reset clears it.

## Timing
- **Reset**: `in_reset` low immediately forces the following, regardless of clock: state S_IDLE, `out_result` 0, `out_done` 0, `out_busy` 0, `out_error` 0, index and accumulator 0.
- **Reset mid-operation**: the operation is discarded and no done pulse is issued.
- **Acceptance**: a grant sampled at rising edge k (state S_IDLE) moves the state to S_EXEC. `out_busy` is high from after edge k.
- **add/sub/and**: `out_result` updates at edge k+1; `out_done[i]` is high for exactly the cycle between edges k+1 and k+2.
- **mul**: `out_result` updates at edge k+data_w; `out_done[i]` is high for one cycle after that edge.
- **Release**: the earliest return to S_IDLE is the edge after S_DONE, provided the grant is already low.
  - The next acceptance can occur on the following edge.
  - The arbiter inserts at least one zero-grant cycle, so there is no back-to-back overlap.
- **`out_error`**: high for exactly one cycle after the offending edge.
- **Registered outputs**: all outputs are registered; there is no combinational path from the inputs to the outputs.

## Test plan
- **Reset values**: assert `in_reset` low mid-multiply with A=8'hFF, B=8'hFF, width=4, data_w=8 -> all outputs 0 immediately, no `out_done`; after release the FSM accepts a new grant.
- **Add on requester 2**: grant=4'b0100, A2=8'd200, B2=8'd100, op=00 -> `out_result`=16'h012C one edge after acceptance; `out_done`=4'b0100 for one cycle; `out_busy` falls after the grant drops.
- **Sub with borrow on requester 0**: A0=8'd5, B0=8'd7, op=01 -> `out_result`=16'h01FE, done pulse on bit 0.
- **Multiply on requester 3**: A3=8'hFF, B3=8'hFF, op=11 -> `out_result`=16'hFE01 exactly 8 edges after acceptance, single done pulse on bit 3.
  - Changing A3 during S_EXEC has no effect on the result.
- **Abort**: start mul on requester 1 and drop the grant after 3 cycles -> FSM returns to S_IDLE, no `out_done`, `out_result` holds its previous value.
- **Invalid grant and arbiter integration**: grant=4'b0110 -> `out_error` 1-cycle pulse, stays S_IDLE.
  - Then chain with the arbiter for requests 4'b0011, each requester dropping its request on done -> requester 0 is served, then requester 1, each with exactly one done pulse.
